store_buffer: RTL and testbench

//  FIFO write buffer between the core's load/store path and the data memory.

---
 rtl/store_buffer.sv | 139 +++++++++++++
 tb/tb_store_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO store buffer owning the data-memory port; loads bypass clean, stall on overlap.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    st_valid_i,
    output logic                    st_ready_o,
    input  logic [ADDR_W-1:0]       st_addr_i,
    input  logic [DATA_W-1:0]       st_data_i,
    input  logic [2:0]              st_funct3_i,
    input  logic                    ld_valid_i,
    input  logic [ADDR_W-1:0]       ld_addr_i,
    input  logic [2:0]              ld_funct3_i,
    output logic                    ld_stall_o,
    input  logic                    flush_i,
    output logic                    flush_busy_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [DATA_W-1:0]       mem_data_o,
    output logic [2:0]              mem_funct3_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = ADDR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [2:0]        f3_q   [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush_pend_q, flush_pend_d;

    logic full, empty, push, pop, load_go, hit;
    logic [RW-1:0] ld_lo, ld_hi, s_lo, s_hi;
    logic [PW-1:0] off;

    // Access size in bytes from funct3[1:0]; anything not byte/half counts as a word.
    function automatic logic [RW-1:0] size_of(input logic [1:0] f);
        case (f)
            2'b00:   size_of = RW'(1);
            2'b01:   size_of = RW'(2);
            default: size_of = RW'(4);
        endcase
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign st_ready_o = !full;
    assign push = st_valid_i && !full &&
                  (st_funct3_i == 3'b000 || st_funct3_i == 3'b001 || st_funct3_i == 3'b010);

    // Ranges are widened by one bit so an access near the top of memory never wraps to 0.
    always_comb begin
        ld_lo = {1'b0, ld_addr_i};
        ld_hi = ld_lo + size_of(ld_funct3_i[1:0]) - RW'(1);
        hit   = 1'b0;
        s_lo  = '0;
        s_hi  = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if ({1'b0, off} < count_q) begin
                s_lo = {1'b0, addr_q[i]};
                s_hi = s_lo + size_of(f3_q[i][1:0]) - RW'(1);
                if (s_lo <= ld_hi && ld_lo <= s_hi) begin
                    hit = 1'b1;
                end
            end
        end
    end

    assign ld_stall_o = ld_valid_i && hit;
    assign load_go    = ld_valid_i && !hit;
    assign pop        = !load_go && !empty;

    always_comb begin
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_funct3_o = '0;
        if (load_go) begin
            mem_read_o   = 1'b1;
            mem_addr_o   = ld_addr_i;
            mem_funct3_o = ld_funct3_i;
        end else if (!empty) begin
            mem_write_o  = 1'b1;
            mem_addr_o   = addr_q[head_q];
            mem_data_o   = data_q[head_q];
            mem_funct3_o = f3_q[head_q];
        end
    end

    always_comb begin
        head_d = pop ? head_q + PW'(1) : head_q;
        tail_d = push ? tail_q + PW'(1) : tail_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        flush_pend_d = (flush_i || flush_pend_q) && (count_d != '0);
    end

    assign flush_busy_o = (flush_i || flush_pend_q) && !empty;
    assign count_o      = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Entry payload needs no reset: occupancy is governed solely by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q] <= st_addr_i;
            data_q[tail_q] <= st_data_i;
            f3_q[tail_q]   <= st_funct3_i;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - table-driven and directed checks for store_buffer.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_ready;
    logic [7:0]  st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        ld_valid;
    logic [7:0]  ld_addr;
    logic [2:0]  ld_funct3;
    logic        ld_stall, flush, flush_busy;
    logic        mem_read, mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic [2:0]  mem_funct3;
    logic [2:0]  count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .ADDR_W(8), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .st_valid_i(st_valid), .st_ready_o(st_ready),
        .st_addr_i(st_addr), .st_data_i(st_data), .st_funct3_i(st_funct3),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_funct3_i(ld_funct3),
        .ld_stall_o(ld_stall), .flush_i(flush), .flush_busy_o(flush_busy),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_data_o(mem_data), .mem_funct3_o(mem_funct3), .count_o(count)
    );

    typedef struct {
        logic        rst, stv;
        logic [7:0]  sta;
        logic [31:0] std;
        logic [2:0]  stf;
        logic        ldv;
        logic [7:0]  lda;
        logic [2:0]  ldf;
        logic        fl;
        logic [50:0] exp;
    } vec_t;

    vec_t vecs[$];

    // exp = {st_ready, ld_stall, flush_busy, mem_read, mem_write, addr, data, funct3, count}
    function automatic vec_t mk(
        input logic r, input logic sv, input logic [7:0] sa, input logic [31:0] sd,
        input logic [2:0] sf, input logic lv, input logic [7:0] la, input logic [2:0] lf,
        input logic f, input logic e_rdy, input logic e_stall, input logic e_fb,
        input logic e_rd, input logic e_wr, input logic [7:0] e_addr,
        input logic [31:0] e_data, input logic [2:0] e_f3, input logic [2:0] e_cnt);
        vec_t v;
        v.rst = r; v.stv = sv; v.sta = sa; v.std = sd; v.stf = sf;
        v.ldv = lv; v.lda = la; v.ldf = lf; v.fl = f;
        v.exp = {e_rdy, e_stall, e_fb, e_rd, e_wr, e_addr, e_data, e_f3, e_cnt};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; flush = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // reset state
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        // single sw drains next cycle
        vecs.push_back(mk(0,1,8'h10,32'hDEADBEEF,3'd2, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,1, 8'h10,32'hDEADBEEF,3'd2, 3'd1));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        // fill to full behind a clean load, 5th ignored, then FIFO-order drain
        vecs.push_back(mk(0,1,8'h00,32'h1,3'd2, 1,8'h80,3'd2, 0, 1,0,0,1,0, 8'h80,32'h0,3'd2, 3'd0));
        vecs.push_back(mk(0,1,8'h04,32'h2,3'd2, 1,8'h80,3'd2, 0, 1,0,0,1,0, 8'h80,32'h0,3'd2, 3'd1));
        vecs.push_back(mk(0,1,8'h08,32'h3,3'd2, 1,8'h80,3'd2, 0, 1,0,0,1,0, 8'h80,32'h0,3'd2, 3'd2));
        vecs.push_back(mk(0,1,8'h0C,32'h4,3'd2, 1,8'h80,3'd2, 0, 1,0,0,1,0, 8'h80,32'h0,3'd2, 3'd3));
        vecs.push_back(mk(0,1,8'h10,32'h5,3'd2, 1,8'h80,3'd2, 0, 0,0,0,1,0, 8'h80,32'h0,3'd2, 3'd4));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 0,0,0,0,1, 8'h00,32'h1,3'd2, 3'd4));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,1, 8'h04,32'h2,3'd2, 3'd3));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,1, 8'h08,32'h3,3'd2, 3'd2));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,1, 8'h0C,32'h4,3'd2, 3'd1));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        // sb 0x23 vs lw 0x20: stall while store drains, then load proceeds
        vecs.push_back(mk(0,1,8'h23,32'hAB,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 1,8'h20,3'd2, 0, 1,1,0,0,1, 8'h23,32'hAB,3'd0, 3'd1));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 1,8'h20,3'd2, 0, 1,0,0,1,0, 8'h20,32'h0,3'd2, 3'd0));
        // sh 0x40 vs lbu 0x42: disjoint, load wins the port
        vecs.push_back(mk(0,1,8'h40,32'h1234,3'd1, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 1,8'h42,3'd4, 0, 1,0,0,1,0, 8'h42,32'h0,3'd4, 3'd1));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,1, 8'h40,32'h1234,3'd1, 3'd1));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        // 3 entries then flush pulse: busy for exactly 3 cycles
        vecs.push_back(mk(0,1,8'h00,32'h11,3'd2, 1,8'h80,3'd2, 0, 1,0,0,1,0, 8'h80,32'h0,3'd2, 3'd0));
        vecs.push_back(mk(0,1,8'h04,32'h22,3'd2, 1,8'h80,3'd2, 0, 1,0,0,1,0, 8'h80,32'h0,3'd2, 3'd1));
        vecs.push_back(mk(0,1,8'h08,32'h33,3'd2, 1,8'h80,3'd2, 0, 1,0,0,1,0, 8'h80,32'h0,3'd2, 3'd2));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 1, 1,0,1,0,1, 8'h00,32'h11,3'd2, 3'd3));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,1,0,1, 8'h04,32'h22,3'd2, 3'd2));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,1,0,1, 8'h08,32'h33,3'd2, 3'd1));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 1, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        // unsupported store funct3 is not pushed
        vecs.push_back(mk(0,1,8'h10,32'h99,3'd3, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        // sw at 0xFE: range does not wrap onto 0x00, but covers 0xFF
        vecs.push_back(mk(0,1,8'hFE,32'h77,3'd2, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 1,8'h00,3'd0, 0, 1,0,0,1,0, 8'h00,32'h0,3'd0, 3'd1));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 1,8'hFF,3'd0, 0, 1,1,0,0,1, 8'hFE,32'h77,3'd2, 3'd1));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 1,8'hFF,3'd0, 0, 1,0,0,1,0, 8'hFF,32'h0,3'd0, 3'd0));
        // unsupported load funct3 checks overlap as a word
        vecs.push_back(mk(0,1,8'h33,32'h5,3'd0, 0,8'h00,3'd0, 0, 1,0,0,0,0, 8'h00,32'h0,3'd0, 3'd0));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 1,8'h30,3'd3, 0, 1,1,0,0,1, 8'h33,32'h5,3'd0, 3'd1));
        vecs.push_back(mk(0,0,8'h00,32'h0,3'd0, 1,8'h30,3'd3, 0, 1,0,0,1,0, 8'h30,32'h0,3'd3, 3'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; st_valid = vecs[i].stv; st_addr = vecs[i].sta;
            st_data = vecs[i].std; st_funct3 = vecs[i].stf;
            ld_valid = vecs[i].ldv; ld_addr = vecs[i].lda; ld_funct3 = vecs[i].ldf;
            flush = vecs[i].fl;
            #1;
            check($sformatf("vec%0d", i),
                  64'({st_ready, ld_stall, flush_busy, mem_read, mem_write,
                       mem_addr, mem_data, mem_funct3, count}),
                  64'(vecs[i].exp));
            @(posedge clk); #1;
        end

        // pointer wrap with one pop per cycle, then reset in the middle of the drain
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            st_valid = 1'b1; st_funct3 = 3'd2;
            st_addr = 8'(8'h50 + 4 * k); st_data = 32'(32'hA0 + k);
            #1;
            if (k > 0) begin
                check($sformatf("wrap_wr%0d", k), 64'(mem_write), 64'd1);
                check($sformatf("wrap_addr%0d", k), 64'(mem_addr), 64'(8'h50 + 4 * (k - 1)));
                check($sformatf("wrap_data%0d", k), 64'(mem_data), 64'(32'hA0 + k - 1));
            end
            @(posedge clk); #1;
        end
        rst = 1'b1; st_addr = 8'h64; st_data = 32'hA5;
        #1;
        check("pre_rst_count", 64'(count), 64'd1);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_st_ready", 64'(st_ready), 64'd1);
        check("rst_flush_busy", 64'(flush_busy), 64'd0);
        st_valid = 1'b1; st_addr = 8'h70; st_data = 32'hCAFE; st_funct3 = 3'd2;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        check("post_rst_addr", 64'(mem_addr), 64'h70);
        check("post_rst_data", 64'(mem_data), 64'hCAFE);
        check("post_rst_count", 64'(count), 64'd1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
